// File: rtl/cond_parser_pkg.sv
// Shared types and character constants for the conditional-assignment parser.
package cond_parser_pkg;

  typedef enum logic [4:0] {
    S_IDLE, S_I, S_F, S_VAR, S_OP1, S_OP2, S_NUMC, S_T1, S_EQ1, S_NUM1,
    S_E, S_L, S_S, S_E2, S_T2, S_EQ2, S_NUM2, S_TERM, S_EVAL, S_RESP, S_DRAIN
  } state_t;

  typedef enum logic [2:0] {OP_EQ, OP_NE, OP_LT, OP_GT, OP_LE, OP_GE} op_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHAR = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_MISS = 2'd3;

  localparam logic [6:0] CH_SP   = 7'h20;
  localparam logic [6:0] CH_BANG = 7'h21;
  localparam logic [6:0] CH_0    = 7'h30;
  localparam logic [6:0] CH_9    = 7'h39;
  localparam logic [6:0] CH_SEMI = 7'h3B;
  localparam logic [6:0] CH_LT   = 7'h3C;
  localparam logic [6:0] CH_EQ   = 7'h3D;
  localparam logic [6:0] CH_GT   = 7'h3E;
  localparam logic [6:0] CH_E    = 7'h65;
  localparam logic [6:0] CH_F    = 7'h66;
  localparam logic [6:0] CH_I    = 7'h69;
  localparam logic [6:0] CH_L    = 7'h6C;
  localparam logic [6:0] CH_S    = 7'h73;

  function automatic logic is_digit(input logic [6:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Base-10 digit accumulator; flags a push that would reach 2**W.
module dec_accum #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [3:0]   digit,
  output logic [W-1:0] value,
  output logic         has_digit,
  output logic         ovf_c
);

  localparam int unsigned XW = W + 4;

  logic [XW-1:0] next_c;

  // value*10+digit fits in W+4 bits; any upper bit set means overflow
  assign next_c = XW'(value) * XW'(10) + XW'(digit);
  assign ovf_c  = |next_c[XW-1:W];

  // accumulator register: clear wins over push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= '0;
      has_digit <= 1'b0;
    end else if (clr) begin
      value     <= '0;
      has_digit <= 1'b0;
    end else if (push) begin
      value     <= next_c[W-1:0];
      has_digit <= 1'b1;
    end
  end

endmodule

// File: rtl/cond_assign_parser.sv
// Streaming parser/evaluator for "if <V> <op> <N> <T>=<N> else <T>=<N>;".
module cond_assign_parser
  import cond_parser_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter logic [6:0]  VAR_CH = 7'h78,
  parameter logic [6:0]  TGT_CH = 7'h70
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x,
  input  logic [6:0]   in_char,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] res_p,
  output logic         res_err,
  output logic [1:0]   err_code,
  output logic         res_valid,
  input  logic         res_ready
);

  state_t       state, state_d, eff;
  op_t          op, op_d;
  logic [W-1:0] valc, c1, c2;
  logic [W-1:0] res_p_d;
  logic         res_err_d, res_valid_d, in_ready_d;
  logic [1:0]   err_code_d, err_val;
  logic         err_now, hs_c, cond_c;
  logic         acc_clr, acc_push, acc_has, acc_ovf_c;
  logic         cap_valc, cap_c1, cap_c2;
  logic [W-1:0] acc_value;

  assign hs_c = in_valid & in_ready;

  dec_accum #(.W(W)) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (acc_clr),
    .push      (acc_push),
    .digit     (in_char[3:0]),
    .value     (acc_value),
    .has_digit (acc_has),
    .ovf_c     (acc_ovf_c)
  );

  // unsigned comparison of x against the parsed constant
  always_comb begin
    cond_c = 1'b0;
    case (op)
      OP_EQ:   cond_c = (x == valc);
      OP_NE:   cond_c = (x != valc);
      OP_LT:   cond_c = (x <  valc);
      OP_GT:   cond_c = (x >  valc);
      OP_LE:   cond_c = (x <= valc);
      OP_GE:   cond_c = (x >= valc);
      default: cond_c = 1'b0;
    endcase
  end

  // next-state, capture and next-output logic; a number terminator is
  // handed to the successor state in the same cycle via eff
  always_comb begin
    state_d    = state;
    eff        = state;
    op_d       = op;
    acc_clr    = (state == S_IDLE);
    acc_push   = 1'b0;
    cap_valc   = 1'b0;
    cap_c1     = 1'b0;
    cap_c2     = 1'b0;
    err_now    = 1'b0;
    err_val    = ERR_CHAR;
    res_p_d    = res_p;
    res_err_d  = res_err;
    err_code_d = err_code;

    if (state == S_EVAL) begin
      res_p_d    = cond_c ? c1 : c2;
      res_err_d  = 1'b0;
      err_code_d = ERR_NONE;
      state_d    = S_RESP;
    end else if (state == S_RESP) begin
      if (res_ready) state_d = S_IDLE;
    end else if (hs_c) begin
      if ((state inside {S_NUMC, S_NUM1, S_NUM2}) && !is_digit(in_char) && acc_has) begin
        acc_clr = 1'b1;
        case (state)
          S_NUMC:  begin cap_valc = 1'b1; eff = S_T1;   end
          S_NUM1:  begin cap_c1   = 1'b1; eff = S_E;    end
          default: begin cap_c2   = 1'b1; eff = S_TERM; end
        endcase
      end else if (state == S_OP2 && (op == OP_LT || op == OP_GT) && in_char != CH_EQ) begin
        eff = S_NUMC;
      end

      state_d = eff;
      case (eff)
        S_IDLE: if (in_char == CH_I) state_d = S_I;
        S_I:    if (in_char == CH_F) state_d = S_F; else err_now = 1'b1;
        S_F: begin
          if (in_char == CH_SP)       state_d = S_VAR;
          else if (in_char == VAR_CH) state_d = S_OP1;
          else                        err_now = 1'b1;
        end
        S_VAR: begin
          if (in_char == VAR_CH)     state_d = S_OP1;
          else if (in_char != CH_SP) err_now = 1'b1;
        end
        S_OP1: begin
          if (in_char == CH_EQ)        begin op_d = OP_EQ; state_d = S_OP2; end
          else if (in_char == CH_BANG) begin op_d = OP_NE; state_d = S_OP2; end
          else if (in_char == CH_LT)   begin op_d = OP_LT; state_d = S_OP2; end
          else if (in_char == CH_GT)   begin op_d = OP_GT; state_d = S_OP2; end
          else if (in_char != CH_SP)   err_now = 1'b1;
        end
        S_OP2: begin
          if (in_char == CH_EQ) begin
            state_d = S_NUMC;
            if (op == OP_LT)      op_d = OP_LE;
            else if (op == OP_GT) op_d = OP_GE;
          end else begin
            err_now = 1'b1;
          end
        end
        S_NUMC, S_NUM1, S_NUM2: begin
          if (is_digit(in_char)) begin
            if (acc_ovf_c) begin err_now = 1'b1; err_val = ERR_OVF; end
            else           acc_push = 1'b1;
          end else if (in_char != CH_SP) begin
            err_now = 1'b1;
            err_val = ERR_MISS;
          end
        end
        S_T1: begin
          if (in_char == TGT_CH)     state_d = S_EQ1;
          else if (in_char != CH_SP) err_now = 1'b1;
        end
        S_EQ1: begin
          if (in_char == CH_EQ)      state_d = S_NUM1;
          else if (in_char != CH_SP) err_now = 1'b1;
        end
        S_E: begin
          if (in_char == CH_E)       state_d = S_L;
          else if (in_char != CH_SP) err_now = 1'b1;
        end
        S_L:  if (in_char == CH_L) state_d = S_S;  else err_now = 1'b1;
        S_S:  if (in_char == CH_S) state_d = S_E2; else err_now = 1'b1;
        S_E2: if (in_char == CH_E) state_d = S_T2; else err_now = 1'b1;
        S_T2: begin
          if (in_char == TGT_CH)     state_d = S_EQ2;
          else if (in_char != CH_SP) err_now = 1'b1;
        end
        S_EQ2: begin
          if (in_char == CH_EQ)      state_d = S_NUM2;
          else if (in_char != CH_SP) err_now = 1'b1;
        end
        S_TERM: begin
          if (in_char == CH_SEMI)    state_d = S_EVAL;
          else if (in_char != CH_SP) err_now = 1'b1;
        end
        S_DRAIN: if (in_char == CH_SEMI) state_d = S_RESP;
        default: err_now = 1'b1;
      endcase

      // an offending ';' also ends the statement
      if (err_now) begin
        state_d    = (in_char == CH_SEMI) ? S_RESP : S_DRAIN;
        err_code_d = err_val;
        res_err_d  = 1'b1;
        res_p_d    = '0;
      end
    end

    res_valid_d = (state_d == S_RESP);
    in_ready_d  = !(state_d == S_EVAL || state_d == S_RESP);
  end

  // state, operand captures and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op        <= OP_EQ;
      valc      <= '0;
      c1        <= '0;
      c2        <= '0;
      in_ready  <= 1'b1;
      res_p     <= '0;
      res_err   <= 1'b0;
      err_code  <= ERR_NONE;
      res_valid <= 1'b0;
    end else begin
      state     <= state_d;
      op        <= op_d;
      if (cap_valc) valc <= acc_value;
      if (cap_c1)   c1   <= acc_value;
      if (cap_c2)   c2   <= acc_value;
      in_ready  <= in_ready_d;
      res_p     <= res_p_d;
      res_err   <= res_err_d;
      err_code  <= err_code_d;
      res_valid <= res_valid_d;
    end
  end

endmodule
